// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch / countdown timer.
package stopwatch_pkg;

  localparam logic [7:0]  BCD_MAX_SEC = 8'h59;
  localparam logic [7:0]  BCD_MAX_MIN = 8'h59;
  localparam int unsigned FRAC_W_MAX  = 12;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One lap FIFO entry; fraction is stored at the widest supported width.
  typedef struct packed {
    logic [FRAC_W_MAX-1:0] frac;
    logic [7:0]            s;
    logic [7:0]            m;
  } lap_entry_t;

  // True when v is a well-formed BCD byte not exceeding max_v.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX with increment/decrement, load and clear.
module bcd_digit_cnt #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry_c,
  output logic       borrow_c,
  output logic       is_zero_c,
  output logic       is_max_c
);

  assign is_zero_c = (q == 4'd0);
  assign is_max_c  = (q == 4'(MAX));
  assign carry_c   = inc & is_max_c;
  assign borrow_c  = dec & is_zero_c;

  // Digit register: clear beats load beats count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= is_max_c ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= is_zero_c ? 4'(MAX) : q - 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_lap.sv
// BCD stopwatch / countdown timer with preset load and lap-capture FIFO.
module stopwatch_bcd_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned FRAC_DIGITS = 1,
  parameter int unsigned LAP_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_stop,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     load,
  input  logic [7:0]               load_m,
  input  logic [7:0]               load_s,
  input  logic                     lap,
  input  logic                     lap_rd,
  output logic                     running,
  output logic [4*FRAC_DIGITS-1:0] cnt_frac,
  output logic [7:0]               cnt_s,
  output logic [7:0]               cnt_m,
  output logic [4*FRAC_DIGITS-1:0] lap_frac,
  output logic [7:0]               lap_s,
  output logic [7:0]               lap_m,
  output logic                     lap_valid,
  output logic                     lap_full,
  output logic                     done,
  output logic                     ovf
);

  localparam int unsigned FW = 4 * FRAC_DIGITS;
  localparam int unsigned ND = FRAC_DIGITS + 4;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [PW-1:0]     presc_q;
  logic              tick, do_inc, do_dec, hit_zero, all_zero, load_ok;
  logic              clr_time, ld_time, done_d;

  logic [ND-1:0][3:0] dq;
  logic [ND-1:0][3:0] ld_val;
  logic [ND-1:0]      inc_en, dec_en, is_zero, is_max, carry, borrow;

  lap_entry_t        fifo_q [LAP_DEPTH];
  lap_entry_t        head, wr_entry;
  logic [AW-1:0]     rd_ptr_q, wr_ptr;
  logic [CW-1:0]     count_q;
  logic              fifo_rd, fifo_wr;

  assign running  = (state_q == ST_RUN);
  assign tick     = running && (presc_q == PW'(TICK_DIV - 1));
  assign all_zero = &is_zero;
  assign hit_zero = do_dec && (dq[0] == 4'd1) && (&is_zero[ND-1:1]);
  assign do_inc   = tick && (mode_q == MODE_UP);
  assign do_dec   = tick && (mode_q == MODE_DOWN) && !all_zero;
  assign load_ok  = bcd_in_range(load_m, BCD_MAX_MIN) && bcd_in_range(load_s, BCD_MAX_SEC);
  assign ld_val   = {load_m, load_s, FW'(0)};

  // Carry / borrow ripple across digits, least significant first.
  always_comb begin
    inc_en    = '0;
    dec_en    = '0;
    inc_en[0] = do_inc;
    dec_en[0] = do_dec;
    for (int i = 1; i < ND; i++) begin
      inc_en[i] = inc_en[i-1] & is_max[i-1];
      dec_en[i] = dec_en[i-1] & is_zero[i-1];
    end
  end

  // Digit chain: fraction digits, then seconds lo/hi, then minutes lo/hi.
  for (genvar i = 0; i < ND; i++) begin : g_digit
    localparam int unsigned DMAX = ((i == FRAC_DIGITS + 1) || (i == FRAC_DIGITS + 3)) ? 5 : 9;
    bcd_digit_cnt #(.MAX(DMAX)) u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_time),
      .ld        (ld_time),
      .ld_val    (ld_val[i]),
      .inc       (inc_en[i]),
      .dec       (dec_en[i]),
      .q         (dq[i]),
      .carry_c   (carry[i]),
      .borrow_c  (borrow[i]),
      .is_zero_c (is_zero[i]),
      .is_max_c  (is_max[i])
    );
  end

  assign cnt_frac = dq[FRAC_DIGITS-1:0];
  assign cnt_s    = {dq[FRAC_DIGITS+1], dq[FRAC_DIGITS]};
  assign cnt_m    = {dq[FRAC_DIGITS+3], dq[FRAC_DIGITS+2]};

  // Next-state and one-cycle controls; clear beats load beats start.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    clr_time = 1'b0;
    ld_time  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          clr_time = 1'b1;
        end else if (load && load_ok) begin
          ld_time = 1'b1;
        end else if (start_stop && !((mode_e'(mode) == MODE_DOWN) && all_zero)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hit_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (start_stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, mode latch, prescaler, done pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      presc_q <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == ST_IDLE) begin
        mode_q <= mode_e'(mode);
      end
      if (clr_time || ld_time) begin
        presc_q <= '0;
      end else if (running) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
      end
      if (clr_time) begin
        ovf <= 1'b0;
      end else if (carry[ND-1]) begin
        ovf <= 1'b1;
      end
    end
  end

  assign lap_valid = (count_q != '0);
  assign lap_full  = (count_q == CW'(LAP_DEPTH));
  assign wr_ptr    = rd_ptr_q + AW'(count_q);
  assign fifo_rd   = lap_rd && lap_valid && !clr_time;
  assign fifo_wr   = running && lap && (!lap_full || fifo_rd);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    wr_entry      = '0;
    wr_entry.frac = FRAC_W_MAX'(cnt_frac);
    wr_entry.s    = cnt_s;
    wr_entry.m    = cnt_m;
  end

  // Lap FIFO pointer and occupancy.
  always_ff @(posedge clk) begin
    if (rst || clr_time) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (fifo_wr && !fifo_rd) begin
        count_q <= count_q + CW'(1);
      end else if (fifo_rd && !fifo_wr) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Lap FIFO storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_q[wr_ptr] <= wr_entry;
    end
  end

  assign lap_frac = lap_valid ? head.frac[FW-1:0] : '0;
  assign lap_s    = lap_valid ? head.s : 8'h00;
  assign lap_m    = lap_valid ? head.m : 8'h00;

  logic unused_sig;
  assign unused_sig = ^{carry[ND-2:0], borrow, is_max[ND-1], head.frac};

endmodule

// File: tb/tb_stopwatch_bcd_lap.sv
// Randomised and directed bench for stopwatch_bcd_lap against a time-in-ticks model.
module tb_stopwatch_bcd_lap;

  localparam int TICK_DIV    = 1;
  localparam int FRAC_DIGITS = 1;
  localparam int LAP_DEPTH   = 4;
  localparam int FR          = 10 ** FRAC_DIGITS;
  localparam int MAXT        = 3600 * FR;

  logic clk, rst, start_stop, clear, mode, load, lap, lap_rd;
  logic [7:0] load_m, load_s;
  logic running, lap_valid, lap_full, done, ovf;
  logic [4*FRAC_DIGITS-1:0] cnt_frac, lap_frac;
  logic [7:0] cnt_s, cnt_m, lap_s, lap_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time as a plain count of fraction units.
  int m_t, m_presc;
  bit m_run, m_mode, m_ovf, m_done;
  int m_q[$];

  stopwatch_bcd_lap #(.TICK_DIV(TICK_DIV), .FRAC_DIGITS(FRAC_DIGITS), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .mode(mode),
    .load(load), .load_m(load_m), .load_s(load_s), .lap(lap), .lap_rd(lap_rd),
    .running(running), .cnt_frac(cnt_frac), .cnt_s(cnt_s), .cnt_m(cnt_m),
    .lap_frac(lap_frac), .lap_s(lap_s), .lap_m(lap_m), .lap_valid(lap_valid),
    .lap_full(lap_full), .done(done), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int x = v;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit tick, pop, push;
    int pre_t;
    tick   = m_run && (m_presc == TICK_DIV - 1);
    pre_t  = m_t;
    m_done = 1'b0;
    if (rst) begin
      m_run = 0; m_t = 0; m_mode = 0; m_ovf = 0; m_presc = 0;
      m_q.delete();
    end else if (!m_run) begin
      m_mode = mode;
      if (lap_rd && m_q.size() > 0 && !clear) void'(m_q.pop_front());
      if (clear) begin
        m_t = 0; m_ovf = 0; m_presc = 0;
        m_q.delete();
      end else if (load && bcd_ok(load_m) && bcd_ok(load_s)) begin
        m_t = (bcd2int(load_m) * 60 + bcd2int(load_s)) * FR;
        m_presc = 0;
      end else if (start_stop && !(mode && m_t == 0)) begin
        m_run = 1;
      end
    end else begin
      pop  = lap_rd && m_q.size() > 0;
      push = lap && (m_q.size() < LAP_DEPTH || pop);
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(pre_t);
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        if (!m_mode) begin
          if (m_t == MAXT - 1) begin m_t = 0; m_ovf = 1; end
          else m_t++;
        end else if (m_t > 0) begin
          m_t--;
          if (m_t == 0) begin m_run = 0; m_done = 1; end
        end
      end
      if (start_stop) m_run = 0;
    end
  endtask

  task automatic compare_all();
    int h;
    h = (m_q.size() > 0) ? m_q[0] : 0;
    check("running",   running,   m_run);
    check("cnt_frac",  cnt_frac,  to_bcd(m_t % FR, FRAC_DIGITS));
    check("cnt_s",     cnt_s,     to_bcd((m_t / FR) % 60, 2));
    check("cnt_m",     cnt_m,     to_bcd(m_t / (FR * 60), 2));
    check("done",      done,      m_done);
    check("ovf",       ovf,       m_ovf);
    check("lap_valid", lap_valid, m_q.size() > 0);
    check("lap_full",  lap_full,  m_q.size() == LAP_DEPTH);
    check("lap_frac",  lap_frac,  to_bcd(h % FR, FRAC_DIGITS));
    check("lap_s",     lap_s,     to_bcd((h / FR) % 60, 2));
    check("lap_m",     lap_m,     to_bcd(h / (FR * 60), 2));
  endtask

  task automatic cyc(input bit ss, input bit clr, input bit ld, input logic [7:0] lm,
                     input logic [7:0] ls, input bit lp, input bit rd, input bit rs);
    start_stop = ss; clear = clr; load = ld; load_m = lm; load_s = ls;
    lap = lp; lap_rd = rd; rst = rs;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
  endtask

  task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s,
                            input logic [3:0] f);
    check({tag, "_m"}, cnt_m, m);
    check({tag, "_s"}, cnt_s, s);
    check({tag, "_frac"}, cnt_frac, f);
  endtask

  initial begin
    logic [3:0] exp_laps [4];
    exp_laps = '{4'h3, 4'h5, 4'h7, 4'h9};
    mode = 1'b0;
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    check("reset_running", running, 1'b0);

    // Basic up count and stop.
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(600);
    check_time("t600", 8'h01, 8'h00, 4'h0);
    idle(1);
    check_time("t601", 8'h01, 8'h00, 4'h1);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(3);
    check("stopped", running, 1'b0);

    // Wrap from 59:59 with overflow, then clear.
    cyc(0, 0, 1, 8'h59, 8'h59, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(10);
    check_time("wrap", 8'h00, 8'h00, 4'h0);
    check("wrap_ovf", ovf, 1'b1);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    check_time("clr", 8'h00, 8'h00, 4'h0);
    check("clr_ovf", ovf, 1'b0);

    // Countdown from 00:02.0.
    mode = 1'b1;
    cyc(0, 0, 1, 8'h00, 8'h02, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(19);
    check("cd_running", running, 1'b1);
    idle(1);
    check_time("cd_zero", 8'h00, 8'h00, 4'h0);
    check("cd_done", done, 1'b1);
    check("cd_stop", running, 1'b0);
    idle(1);
    check("cd_done_pulse", done, 1'b0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    check("cd_restart_ignored", running, 1'b0);

    // Laps at .3 .5 .7 .9 1.1 into a 4-deep FIFO.
    mode = 1'b0;
    cyc(0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    end
    check("lap_full_after5", lap_full, 1'b1);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("lap_pop_frac", lap_frac, exp_laps[k]);
      check("lap_pop_s", lap_s, 8'h00);
      cyc(0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    end
    check("lap_empty", lap_valid, 1'b0);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1, 0);

    // Invalid and ignored loads, clear beating load.
    cyc(0, 0, 1, 8'h00, 8'h5A, 0, 0, 0);
    cyc(0, 0, 1, 8'h60, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h12, 8'h34, 0, 0, 0);
    check_time("clr_load", 8'h00, 8'h00, 4'h0);

    // Reset in the middle of a run.
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(10);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    idle(23);
    check_time("pre_rst", 8'h00, 8'h03, 4'h4);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    check_time("post_rst", 8'h00, 8'h00, 4'h0);
    check("post_rst_fifo", lap_valid, 1'b0);
    check("post_rst_run", running, 1'b0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] lm, ls;
      if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
      lm = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      ls = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0,
          lm, ls, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 999) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
